// File: rtl/mem_arb_if.sv
// Request/grant, read-return and memory-port bundle for mem_arb.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arb_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren;
  logic [DW-1:0] mem_q;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_q
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_q
  );
endinterface

// File: rtl/mem_arb.sv
// Fetch/data arbiter in front of one single-port synchronous memory.
// Default: data priority with fetch starvation guard; MEM_ARB_RR_EN selects round-robin.
module mem_arb #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  mem_arb_if.slave    bus,
  output logic [15:0] conflict_cnt
);

  logic          contention;
  logic          if_gnt_c;
  logic          dm_gnt_c;

  logic [AW-1:0] addr_q,    addr_d;
  logic [DW-1:0] wdata_q,   wdata_d;
  logic          if_rv_q,   if_rv_d;
  logic          dm_rv_q,   dm_rv_d;
  logic [DW-1:0] if_hold_q, if_hold_d;
  logic [DW-1:0] dm_hold_q, dm_hold_d;
  logic [15:0]   conf_q,    conf_d;

`ifdef MEM_ARB_RR_EN
  typedef enum logic {NEXT_IF = 1'b0, NEXT_DM = 1'b1} rr_e;
  rr_e rr_q, rr_d;
`else
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
`endif

  assign contention = bus.if_req & bus.dm_req;

  always_comb begin
    if_gnt_c = 1'b0;
    dm_gnt_c = 1'b0;
    if (!rst) begin
      if (contention) begin
`ifdef MEM_ARB_RR_EN
        if_gnt_c = (rr_q == NEXT_IF);
`else
        if_gnt_c = (starve_q == SW'(STARVE_MAX));
`endif
        dm_gnt_c = ~if_gnt_c;
      end else begin
        if_gnt_c = bus.if_req;
        dm_gnt_c = bus.dm_req;
      end
    end
  end

  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_rv_d   = if_gnt_c;
    dm_rv_d   = dm_gnt_c & ~bus.dm_we;
    if_hold_d = if_rv_q ? bus.mem_q : if_hold_q;
    dm_hold_d = dm_rv_q ? bus.mem_q : dm_hold_q;
    conf_d    = conf_q;
    if (if_gnt_c) begin
      addr_d = bus.if_addr;
    end else if (dm_gnt_c) begin
      addr_d  = bus.dm_addr;
      wdata_d = bus.dm_wdata;
    end
    if (contention && (conf_q != '1)) begin
      conf_d = conf_q + 16'd1;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (contention && !rst) begin
      rr_d = if_gnt_c ? NEXT_DM : NEXT_IF;
    end
  end
`else
  // Cannot pass STARVE_MAX: at that value any pending fetch wins.
  always_comb begin
    starve_d = '0;
    if (bus.if_req && !if_gnt_c) begin
      starve_d = starve_q + SW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      if_rv_q   <= 1'b0;
      dm_rv_q   <= 1'b0;
      if_hold_q <= '0;
      dm_hold_q <= '0;
      conf_q    <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_rv_q   <= if_rv_d;
      dm_rv_q   <= dm_rv_d;
      if_hold_q <= if_hold_d;
      dm_hold_q <= dm_hold_d;
      conf_q    <= conf_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= NEXT_IF;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Grant-cycle address is combinational; otherwise the last granted address is held.
  assign bus.mem_addr  = if_gnt_c ? bus.if_addr : (dm_gnt_c ? bus.dm_addr : addr_q);
  assign bus.mem_wdata = dm_gnt_c ? bus.dm_wdata : wdata_q;
  assign bus.mem_wren  = dm_gnt_c & bus.dm_we;

  assign bus.if_gnt    = if_gnt_c;
  assign bus.dm_gnt    = dm_gnt_c;
  assign bus.if_rvalid = if_rv_q;
  assign bus.dm_rvalid = dm_rv_q;
  assign bus.if_rdata  = if_rv_q ? bus.mem_q : if_hold_q;
  assign bus.dm_rdata  = dm_rv_q ? bus.mem_q : dm_hold_q;
  assign conflict_cnt  = conf_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized bench for mem_arb against a cycle-level behavioural model with its own memory image.
module tb_mem_arb;
  localparam int AW         = 8;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] conflict_cnt;

  mem_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  // Environment memory: synchronous single port, plus a preload port for the bench.
  logic [DW-1:0] env_mem [256];
  logic [DW-1:0] mem_q_r;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) env_mem[pre_addr] <= pre_data;
    else if (bus.mem_wren) env_mem[bus.mem_addr] <= bus.mem_wdata;
    mem_q_r <= env_mem[bus.mem_addr];
  end
  assign bus.mem_q = mem_q_r;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] refmem [256];
  int            m_starve     = 0;
  bit            m_fetch_next = 1'b1;
  int            m_conf       = 0;
  bit            m_if_rv = 0, m_dm_rv = 0;
  logic [DW-1:0] m_if_data = '0, m_dm_data = '0, m_if_last = '0, m_dm_last = '0;
  logic [AW-1:0] m_last_addr = '0;
  bit            g_if = 0, g_dm = 0;

  logic          obs_if_gnt, obs_dm_gnt, obs_if_rv, obs_dm_rv, obs_wren;
  logic [DW-1:0] obs_if_rdata, obs_dm_rdata;
  logic [15:0]   obs_conf;

  task automatic step();
    bit            e_if, e_dm, both;
    logic [AW-1:0] e_addr;
    @(negedge clk);
    both = bus.if_req && bus.dm_req;
    e_if = 0;
    e_dm = 0;
    if (!rst) begin
      if (both) begin
`ifdef MEM_ARB_RR_EN
        e_if = m_fetch_next;
`else
        e_if = (m_starve == STARVE_MAX);
`endif
        e_dm = !e_if;
      end else begin
        e_if = bus.if_req;
        e_dm = bus.dm_req;
      end
    end
    e_addr = e_if ? bus.if_addr : (e_dm ? bus.dm_addr : m_last_addr);

    check("if_gnt", 64'(bus.if_gnt), 64'(e_if));
    check("dm_gnt", 64'(bus.dm_gnt), 64'(e_dm));
    check("mem_wren", 64'(bus.mem_wren), 64'(e_dm && bus.dm_we));
    check("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    if (e_dm && bus.dm_we) check("mem_wdata", 64'(bus.mem_wdata), 64'(bus.dm_wdata));
    check("if_rvalid", 64'(bus.if_rvalid), 64'(m_if_rv));
    check("dm_rvalid", 64'(bus.dm_rvalid), 64'(m_dm_rv));
    check("if_rdata", 64'(bus.if_rdata), 64'(m_if_rv ? m_if_data : m_if_last));
    check("dm_rdata", 64'(bus.dm_rdata), 64'(m_dm_rv ? m_dm_data : m_dm_last));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));

    obs_if_gnt   = bus.if_gnt;
    obs_dm_gnt   = bus.dm_gnt;
    obs_if_rv    = bus.if_rvalid;
    obs_dm_rv    = bus.dm_rvalid;
    obs_wren     = bus.mem_wren;
    obs_if_rdata = bus.if_rdata;
    obs_dm_rdata = bus.dm_rdata;
    obs_conf     = conflict_cnt;

    if (rst) begin
      m_starve = 0; m_fetch_next = 1; m_conf = 0;
      m_if_rv = 0; m_dm_rv = 0; m_if_last = '0; m_dm_last = '0;
      m_last_addr = '0;
    end else begin
      if (m_if_rv) m_if_last = m_if_data;
      if (m_dm_rv) m_dm_last = m_dm_data;
      m_if_rv = e_if;
      if (e_if) m_if_data = refmem[bus.if_addr];
      m_dm_rv = e_dm && !bus.dm_we;
      if (m_dm_rv) m_dm_data = refmem[bus.dm_addr];
      if (e_dm && bus.dm_we) refmem[bus.dm_addr] = bus.dm_wdata;
      if (both && m_conf < 65535) m_conf++;
      m_starve = (bus.if_req && !e_if) ? m_starve + 1 : 0;
      if (both) m_fetch_next = !e_if;
      if (e_if || e_dm) m_last_addr = e_addr;
    end
    g_if = e_if;
    g_dm = e_dm;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Preload memory while reset is held.
    pre_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pre_addr = AW'(i);
      pre_data = (i == 16) ? 32'hDEADBEEF : $urandom;
      refmem[i] = pre_data;
      @(posedge clk);
      #1;
    end
    pre_we = 1'b0;
    @(posedge clk);
    #1;

    // Reset state observed with rst still high, and requests forced off.
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    step();
    check("rst_if_gnt", 64'(obs_if_gnt), 64'd0);
    check("rst_dm_gnt", 64'(obs_dm_gnt), 64'd0);
    check("rst_wren", 64'(obs_wren), 64'd0);
    do_reset();

    // Single fetch read
    bus.if_req = 1; bus.if_addr = 8'h10;
    step();
    check("fetch_gnt_c0", 64'(obs_if_gnt), 64'd1);
    bus.if_req = 0;
    step();
    check("fetch_rvalid_c1", 64'(obs_if_rv), 64'd1);
    check("fetch_rdata_c1", 64'(obs_if_rdata), 64'hDEADBEEF);
    step();
    check("fetch_rvalid_drop", 64'(obs_if_rv), 64'd0);
    check("fetch_rdata_hold", 64'(obs_if_rdata), 64'hDEADBEEF);

    // Store then load from the same address
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 8'h20; bus.dm_wdata = 32'h12345678;
    step();
    check("store_wren_c0", 64'(obs_wren), 64'd1);
    bus.dm_we = 0;
    step();
    check("load_gnt_c1", 64'(obs_dm_gnt), 64'd1);
    bus.dm_req = 0;
    step();
    check("load_rvalid_c2", 64'(obs_dm_rv), 64'd1);
    check("load_rdata_c2", 64'(obs_dm_rdata), 64'h12345678);

    // Sustained contention for 10 cycles
    do_reset();
    bus.if_req = 1; bus.if_addr = 8'h01;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 8'h02;
    for (int i = 0; i < 10; i++) begin
      step();
`ifdef MEM_ARB_RR_EN
      check("contend_if_gnt", 64'(obs_if_gnt), 64'((i % 2) == 0));
`else
      check("contend_if_gnt", 64'(obs_if_gnt), 64'((i % 5) == 4));
`endif
      check("contend_one_gnt", 64'(obs_if_gnt ^ obs_dm_gnt), 64'd1);
    end
    bus.if_req = 0; bus.dm_req = 0;
    step();
    check("contend_conflict_cnt", 64'(obs_conf), 64'd10);

    // Reset asserted in the cycle a read would be granted
    bus.if_req = 1; bus.if_addr = 8'h10;
    rst = 1;
    step();
    check("rstgrant_if_gnt", 64'(obs_if_gnt), 64'd0);
    rst = 0; bus.if_req = 0;
    step();
    check("rstgrant_rvalid", 64'(obs_if_rv), 64'd0);
    check("rstgrant_rdata", 64'(obs_if_rdata), 64'd0);
    check("rstgrant_conflict", 64'(obs_conf), 64'd0);

    // Randomized traffic with occasional reset
    for (int c = 0; c < 4000; c++) begin
      if (!bus.if_req || g_if) begin
        bus.if_req  = ($urandom_range(0, 3) != 0);
        bus.if_addr = AW'($urandom_range(0, 15));
      end
      if (!bus.dm_req || g_dm) begin
        bus.dm_req   = ($urandom_range(0, 3) != 0);
        bus.dm_we    = $urandom_range(0, 1) == 1;
        bus.dm_addr  = AW'($urandom_range(0, 15));
        bus.dm_wdata = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0;

    // Saturation of the contention counter
    do_reset();
    bus.if_req = 1; bus.if_addr = 8'h03;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 8'h04;
    for (int i = 0; i < 65540; i++) step();
    bus.if_req = 0; bus.dm_req = 0;
    step();
    check("conflict_saturate", 64'(obs_conf), 64'hFFFF);
    step();
    check("conflict_no_wrap", 64'(obs_conf), 64'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width.
REQ-002 SHALL have parameter DW, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, maximum consecutive denied cycles for a pending fetch request.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port if_req, input, 1, fetch read request; held with if_addr until granted.
REQ-007 SHALL have port if_addr, input, AW, fetch address (PC).
REQ-008 SHALL have ports if_gnt (output, 1), if_rvalid (output, 1) and if_rdata (output, DW), for fetch grant, read-data valid and read data.
REQ-009 SHALL have port dm_req, input, 1, data request; held with dm_we, dm_addr and dm_wdata until granted.
REQ-010 SHALL have ports dm_we (input, 1), dm_addr (input, AW) and dm_wdata (input, DW), for the write flag (1 = store, 0 = load), data address and store data.
REQ-011 SHALL have ports dm_gnt (output, 1), dm_rvalid (output, 1) and dm_rdata (output, DW), for data grant, load-data valid and load data.
REQ-012 SHALL have ports mem_addr (output, AW), mem_wdata (output, DW) and mem_wren (output, 1), which drive the single-port synchronous memory.
REQ-013 SHALL have port mem_q, input, DW, memory read data, valid one cycle after its address.
REQ-014 SHALL have port conflict_cnt, output, 16, saturating count of cycles with both requests pending.

Function
REQ-015 SHALL grant at most one requester per cycle; if_gnt and dm_gnt SHALL be combinational from requests and registered state, and never both 1.
REQ-016 SHALL drive mem_addr, mem_wdata and mem_wren from the granted requester in the grant cycle; mem_wren=1 only for a granted store; with no grant, mem_wren=0 and mem_addr holds its last value.
REQ-017 SHALL assert the matching rvalid for exactly one cycle, the cycle after a read grant, with rdata=mem_q; stores SHALL produce no rvalid.
REQ-018 SHALL accept back-to-back grants every cycle with no bubble, including read-after-store to the same address, which returns the stored data.
REQ-019 SHALL grant the lone requester when only one request is pending.
REQ-020 SHALL, when both request and macro is absent, grant data, unless the starvation counter equals STARVE_MAX, in which case fetch SHALL be granted.
REQ-021 SHALL increment the starvation counter each cycle if_req=1 and if_gnt=0, and clear it on if_gnt or if_req=0.
REQ-022 SHALL increment conflict_cnt each cycle both if_req and dm_req are 1, saturating at 16'hFFFF.
REQ-023 SHALL hold if_rdata and dm_rdata at their last valid value when rvalid=0.

Reset
REQ-024 SHALL, on rst=1 at posedge clk, clear all gnt, rvalid, mem_wren, mem_addr, mem_wdata, rdata, conflict_cnt, the starvation counter and the RR pointer (to fetch-next) to 0.
REQ-025 SHALL suppress rvalid for a read granted in the cycle rst is asserted.
REQ-026 SHALL force both gnt outputs and mem_wren to 0 while rst=1, regardless of requests.

Configuration
REQ-027 SHALL, with MEM_ARB_RR_EN defined, replace REQ-020 with round-robin: on contention grant the requester not granted at the last contention (fetch first after reset); the starvation counter is not built.
REQ-028 SHALL, without MEM_ARB_RR_EN, implement REQ-020/REQ-021 fixed priority with the starvation guard.

Verification
REQ-029 SHALL cover: if_req=1, if_addr=8'h10, mem holding 32'hDEADBEEF -> if_gnt=1 in cycle 0, if_rvalid=1 with if_rdata=32'hDEADBEEF in cycle 1.
REQ-030 SHALL cover: store dm_addr=8'h20, dm_wdata=32'h12345678, then a load from 8'h20 in the next cycle -> mem_wren=1 in cycle 0, dm_rvalid=1 with 32'h12345678 in cycle 2.
REQ-031 SHALL cover: both requests held for 10 cycles without the macro -> dm_gnt for 4 cycles, then if_gnt in cycle 4, repeating; conflict_cnt=10.
REQ-032 SHALL cover: both requests held with MEM_ARB_RR_EN -> grants alternate if, dm, if, dm...
REQ-033 SHALL cover: rst asserted in the cycle of a read grant -> no rvalid in the next cycle; all outputs 0.
REQ-034 SHALL cover: conflict_cnt preloaded by 65540 contention cycles -> value 16'hFFFF, no wrap.
